polirv_fetch: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined polirv core; replaces the direct PC-to-i_mem_addr wiring of the single-cycle top.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake, which tolerates variable memory latency.
- Buffers returned instructions with their PC in a prefetch FIFO, handed to decode over valid/ready.
- Supports redirects from branches and jumps: flushes the queue and discards any in-flight response.

---
 rtl/polirv_pkg.sv | 15 +
 rtl/polirv_fetch_if.sv | 23 ++
 rtl/polirv_sync_fifo.sv | 63 ++++++
 rtl/polirv_fetch.sv | 142 ++++++++++++++
 tb/tb_polirv_fetch.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/polirv_pkg.sv
// Shared types and constants for the polirv fetch front end.
package polirv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    // IDLE: no request; BUSY: request live and wanted; DRAIN: request live but stale.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/polirv_fetch_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and memory (slave).
interface polirv_fetch_if #(
    parameter int unsigned I_ADDR_BITS = 6
);
    logic                   i_mem_req;
    logic [I_ADDR_BITS-1:0] i_mem_addr;
    logic                   i_mem_ack;
    logic [31:0]            i_mem_data;

    modport master (
        output i_mem_req,
        output i_mem_addr,
        input  i_mem_ack,
        input  i_mem_data
    );

    modport slave (
        input  i_mem_req,
        input  i_mem_addr,
        output i_mem_ack,
        output i_mem_data
    );
endinterface

// File: rtl/polirv_sync_fifo.sv
// Synchronous FIFO with registered storage, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module polirv_sync_fifo #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers and count; flush empties the queue without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/polirv_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time over
// req/ack, and queues returned words with their PC for decode.
// Optional macro POLIRV_FETCH_BYPASS_EN: an ack into an empty queue with decode ready
// is forwarded combinationally instead of being queued.
module polirv_fetch
    import polirv_pkg::*;
#(
    parameter int unsigned           I_ADDR_BITS = 6,
    parameter int unsigned           FIFO_DEPTH  = 4,
    parameter logic [I_ADDR_BITS-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    polirv_fetch_if.master         imem,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INSTR_W-1:0]     inst_data,
    output logic [I_ADDR_BITS-1:0] inst_pc,
    input  logic                   redirect_valid,
    input  logic [I_ADDR_BITS-1:0] redirect_pc
);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = INSTR_W + I_ADDR_BITS;
    localparam logic [I_ADDR_BITS-1:0] STEP = I_ADDR_BITS'(PC_STEP);

    fetch_state_e           state_q, state_d;
    logic [I_ADDR_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [I_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [I_ADDR_BITS-1:0] redirect_tgt, next_pc;
    logic                   busy_ack, bypass, space;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count, count_next;
    logic [ENTRY_W-1:0]     fifo_rdata;

    assign redirect_tgt = {redirect_pc[I_ADDR_BITS-1:2], 2'b00};
    assign next_pc      = fetch_pc_q + STEP;
    assign busy_ack     = (state_q == BUSY) & imem.i_mem_ack;

`ifdef POLIRV_FETCH_BYPASS_EN
    assign bypass = fifo_empty & busy_ack & ~redirect_valid & inst_ready;
`else
    assign bypass = 1'b0;
`endif

    // Redirect wins over push and pop; the queue is flushed at the same edge.
    assign fifo_push = busy_ack & ~redirect_valid & ~bypass & ~fifo_full;
    assign fifo_pop  = ~fifo_empty & inst_ready & ~redirect_valid;

    // Occupancy after this cycle's push/pop decides whether a new request may issue.
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign space      = (count_next < CNT_W'(FIFO_DEPTH));

    // Next-state, fetch PC and request address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end else if (space) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (imem.i_mem_ack) begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_tgt;
                        state_d    = IDLE;
                    end else begin
                        fetch_pc_d = next_pc;
                        if (space) begin
                            req_addr_d = next_pc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_tgt;
                end
                if (imem.i_mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, fetch PC and request address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign imem.i_mem_req  = (state_q == BUSY) | (state_q == DRAIN);
    assign imem.i_mem_addr = req_addr_q;

    polirv_sync_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (FIFO_DEPTH),
        .RESET_VAL ({NOP, {I_ADDR_BITS{1'b0}}})
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({imem.i_mem_data, req_addr_q}),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode-side outputs; an empty queue presents zeros.
    always_comb begin
        inst_valid = ~fifo_empty;
        inst_data  = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:I_ADDR_BITS];
        inst_pc    = fifo_empty ? '0 : fifo_rdata[I_ADDR_BITS-1:0];
        if (bypass) begin
            inst_valid = 1'b1;
            inst_data  = imem.i_mem_data;
            inst_pc    = req_addr_q;
        end
    end

endmodule

// File: tb/tb_polirv_fetch.sv
// Self-checking bench for polirv_fetch: directed test-plan steps plus a randomized
// phase, with a stream-level scoreboard (consecutive PCs from the last redirect).
module tb_polirv_fetch;

`ifdef POLIRV_FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [5:0]  inst_pc;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_pc = 6'h00;

    int tests = 0;
    int fails = 0;

    polirv_fetch_if #(.I_ADDR_BITS(6)) imem_if ();

    polirv_fetch #(
        .I_ADDR_BITS (6),
        .FIFO_DEPTH  (4),
        .RESET_PC    (6'h00)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_if),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return 32'hA5C3_0000 ^ {a, 2'b01, a, 2'b10, a, 2'b11, a, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after lat waiting cycles (0 = same cycle), drops state on rst.
    int   wait_cnt = 0;
    int   lat_fixed = 0;
    int   lat_rand = 0;
    bit   rand_lat = 1'b0;
    int   ack_cnt = 0;
    logic mem_ack;

    always_comb begin
        mem_ack = imem_if.i_mem_req && (wait_cnt >= (rand_lat ? lat_rand : lat_fixed));
    end
    assign imem_if.i_mem_ack  = mem_ack;
    assign imem_if.i_mem_data = mem_ack ? mem_word(imem_if.i_mem_addr) : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
            ack_cnt  <= 0;
        end else if (imem_if.i_mem_req && !mem_ack) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            if (mem_ack) begin
                ack_cnt  <= ack_cnt + 1;
                lat_rand <= $urandom_range(0, 3);
            end
        end
    end

    // Scoreboard: decode must see consecutive PCs starting at reset PC or redirect target.
    logic [5:0] exp_pc = 6'h00;
    logic [5:0] prev_addr = 6'h00;
    bit         prev_redir = 1'b0;
    bit         prev_pend = 1'b0;
    int         accepts = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc     = 6'h00;
            prev_redir = 1'b0;
            prev_pend  = 1'b0;
        end else begin
            if (prev_redir) chk("sb_valid_after_redirect", 32'(inst_valid), 32'h0);
            if (prev_pend) begin
                chk("sb_req_held", 32'(imem_if.i_mem_req), 32'h1);
                chk("sb_addr_stable", 32'(imem_if.i_mem_addr), 32'(prev_addr));
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & 6'h3C;
            end else if (inst_valid && inst_ready) begin
                chk("sb_inst_pc", 32'(inst_pc), 32'(exp_pc));
                chk("sb_inst_data", inst_data, mem_word(exp_pc));
                exp_pc  = exp_pc + 6'd4;
                accepts = accepts + 1;
            end
            prev_redir = redirect_valid;
            prev_pend  = imem_if.i_mem_req && !mem_ack;
            prev_addr  = imem_if.i_mem_addr;
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    // Leaves the bench at the start of cycle 0 after release (DUT in IDLE).
    task automatic rst_pulse;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        int acc0;

        // Reset state
        nxt();
        at_neg();
        chk("rst_req", 32'(imem_if.i_mem_req), 32'h0);
        chk("rst_addr", 32'(imem_if.i_mem_addr), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", 32'(inst_pc), 32'h0);
        nxt();

        // Zero-wait memory, decode always ready
        rst_pulse();
        inst_ready = 1'b1;
        lat_fixed  = 0;
        for (int k = 0; k < 6; k++) begin
            at_neg();
            if (k == 0) begin
                chk("zw_req_idle", 32'(imem_if.i_mem_req), 32'h0);
            end else begin
                chk("zw_req", 32'(imem_if.i_mem_req), 32'h1);
                chk("zw_addr", 32'(imem_if.i_mem_addr), 32'(4 * (k - 1)));
            end
            chk("zw_valid", 32'(inst_valid), 32'(k >= 1 + LAT));
            if (k >= 1 + LAT) chk("zw_pc", 32'(inst_pc), 32'(4 * (k - 1 - LAT)));
            nxt();
        end

        // Decode stalled, 1-cycle memory: fills exactly FIFO_DEPTH words then stops
        rst_pulse();
        inst_ready = 1'b0;
        lat_fixed  = 1;
        for (int k = 0; k < 12; k++) nxt();
        at_neg();
        chk("full_acks", 32'(ack_cnt), 32'd4);
        chk("full_req", 32'(imem_if.i_mem_req), 32'h0);
        chk("full_valid", 32'(inst_valid), 32'h1);
        chk("full_head_pc", 32'(inst_pc), 32'h0);
        nxt();
        inst_ready = 1'b1;
        at_neg();
        chk("resume_req_idle", 32'(imem_if.i_mem_req), 32'h0);
        nxt();
        at_neg();
        chk("resume_req", 32'(imem_if.i_mem_req), 32'h1);
        chk("resume_addr", 32'(imem_if.i_mem_addr), 32'h10);
        chk("resume_head_pc", 32'(inst_pc), 32'h04);
        nxt();

        // Redirect while 0x08 pending; its ack arrives three cycles later
        rst_pulse();
        lat_fixed  = 0;
        inst_ready = 1'b1;
        nxt();
        nxt();
        nxt();
        lat_fixed = 3;
        at_neg();
        chk("drain_pending_addr", 32'(imem_if.i_mem_addr), 32'h08);
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 6'h23;
        nxt();
        redirect_valid = 1'b0;
        at_neg();
        chk("drain_valid", 32'(inst_valid), 32'h0);
        chk("drain_req", 32'(imem_if.i_mem_req), 32'h1);
        nxt();
        at_neg();
        chk("drain_ack", 32'(mem_ack), 32'h1);
        nxt();
        lat_fixed = 0;
        at_neg();
        chk("drain_idle_req", 32'(imem_if.i_mem_req), 32'h0);
        chk("drain_idle_valid", 32'(inst_valid), 32'h0);
        nxt();
        at_neg();
        chk("drain_new_req", 32'(imem_if.i_mem_req), 32'h1);
        chk("drain_new_addr", 32'(imem_if.i_mem_addr), 32'h20);
        nxt();

        // Redirect in the same cycle as an ack (0x28)
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 6'h30;
        at_neg();
        chk("same_ack_addr", 32'(imem_if.i_mem_addr), 32'h28);
        chk("same_ack_ack", 32'(mem_ack), 32'h1);
        nxt();
        redirect_valid = 1'b0;
        at_neg();
        chk("same_idle_req", 32'(imem_if.i_mem_req), 32'h0);
        chk("same_idle_valid", 32'(inst_valid), 32'h0);
        nxt();
        at_neg();
        chk("same_new_addr", 32'(imem_if.i_mem_addr), 32'h30);

        // Wrap from 0x3C to 0x00
        nxt();
        redirect_valid = 1'b1;
        redirect_pc    = 6'h3C;
        nxt();
        redirect_valid = 1'b0;
        nxt();
        at_neg();
        chk("wrap_addr_3c", 32'(imem_if.i_mem_addr), 32'h3C);
        nxt();
        at_neg();
        chk("wrap_addr_00", 32'(imem_if.i_mem_addr), 32'h00);
        nxt();

        // Asynchronous reset during BUSY with words queued
        rst_pulse();
        inst_ready = 1'b0;
        lat_fixed  = 0;
        nxt();
        nxt();
        nxt();
        lat_fixed = 3;
        at_neg();
        chk("arst_pre_valid", 32'(inst_valid), 32'h1);
        chk("arst_pre_req", 32'(imem_if.i_mem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(imem_if.i_mem_req), 32'h0);
        chk("arst_valid", 32'(inst_valid), 32'h0);
        chk("arst_addr", 32'(imem_if.i_mem_addr), 32'h00);
        nxt();
        nxt();
        rst        = 1'b0;
        lat_fixed  = 0;
        inst_ready = 1'b1;
        nxt();
        at_neg();
        chk("arst_first_req", 32'(imem_if.i_mem_req), 32'h1);
        chk("arst_first_addr", 32'(imem_if.i_mem_addr), 32'h00);
        nxt();

        // Randomized latency, back-pressure and redirects against the scoreboard
        rst_pulse();
        rand_lat = 1'b1;
        acc0     = accepts;
        for (int i = 0; i < 3000; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 6'($urandom_range(0, 63));
            nxt();
        end
        redirect_valid = 1'b0;
        nxt();
        chk("rand_progress", 32'(accepts - acc0 > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
